// File: rtl/add_resp_pkg.sv
// Shared types and sizing constants for the add_result_responder slice.
package add_resp_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam int PTR_W = $clog2(DEF_FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef logic [DEF_DATA_WIDTH:0] sum_t;

endpackage

// File: rtl/add_resp_fifo.sv
// Synchronous FIFO with push/pop, occupancy level and combinational head read.
module add_resp_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int LW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage is not reset; stale entries are never visible because level gates the head.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/add_result_responder.sv
// Adder endpoint: accepts operand pairs, buffers carry-extended sums, returns them in order.
// Optional build macro: ADD_RESP_COUNT_EN adds the 16-bit txn_count output-transfer counter.
module add_result_responder
  import add_resp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   out_sum,
  output logic [LW-1:0]         out_level
`ifdef ADD_RESP_COUNT_EN
  ,
  output logic [15:0]           txn_count
`endif
);

  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [LW-1:0]       level;
  logic [DATA_WIDTH:0] sum;

  assign sum = {1'b0, in_a} + {1'b0, in_b};

  // Outputs are masked during rst so nothing stale shows before the synchronous clear lands.
  assign out_valid = !rst && !empty;
  assign out_level = rst ? '0 : level;
  assign pop       = out_valid && out_ready;
  assign in_ready  = !rst && (!full || pop);
  assign push      = in_valid && in_ready;

  add_resp_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (sum),
    .pop   (pop),
    .rdata (out_sum),
    .level (level),
    .full  (full),
    .empty (empty)
  );

`ifdef ADD_RESP_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)      txn_count <= '0;
    else if (pop) txn_count <= txn_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_add_result_responder.sv
// Scoreboard bench for add_result_responder: random and directed traffic vs a queue model.
module tb_add_result_responder;
  import add_resp_pkg::*;

  localparam int DW    = DEF_DATA_WIDTH;
  localparam int DEPTH = DEF_FIFO_DEPTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  sum_t          out_sum;
  logic [LVL_W-1:0] out_level;
`ifdef ADD_RESP_COUNT_EN
  logic [15:0]   txn_count;
  logic [15:0]   model_txn;
`endif

  int   errors = 0;
  int   checks = 0;
  int   push_cnt = 0;
  sum_t exp_q[$];
  sum_t last_sum;

  always #5 clk = ~clk;

  add_result_responder #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_level (out_level)
`ifdef ADD_RESP_COUNT_EN
    ,
    .txn_count (txn_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs and outputs are stable at the falling edge; transfers land on the next rise.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_level", 32'(out_level), 32'd0);
      exp_q.delete();
`ifdef ADD_RESP_COUNT_EN
      model_txn = 16'd0;
`endif
    end else begin
      check("out_level", 32'(out_level), 32'(exp_q.size()));
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("in_ready", 32'(in_ready),
            32'((exp_q.size() < DEPTH) || (exp_q.size() != 0 && out_ready)));
`ifdef ADD_RESP_COUNT_EN
      check("txn_count", 32'(txn_count), 32'(model_txn));
`endif
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_on_empty: got sum 0x%0h with no result expected", out_sum);
        end else begin
          check("out_sum", 32'(out_sum), 32'(exp_q.pop_front()));
        end
        last_sum = out_sum;
`ifdef ADD_RESP_COUNT_EN
        model_txn = model_txn + 16'd1;
`endif
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(sum_t'(int'(in_a) + int'(in_b)));
        push_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int start;
    start    = push_cnt;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int i = 0; i < 50 && push_cnt == start; i++) tick();
    if (push_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept for a=0x%0h b=0x%0h expected accept", a, b);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int start;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_a      = 8'h55;
    in_b      = 8'h55;
    out_ready = 1'b1;
    last_sum  = '0;
    repeat (3) tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(in_ready), 32'd1);
    tick();

    send(8'h12, 8'h34);
    drain();
    check("single_sum", 32'(last_sum), 32'h046);
    check("single_level", 32'(out_level), 32'd0);

    send(8'hFF, 8'h01);
    drain();
    check("carry_ff_01", 32'(last_sum), 32'h100);
    send(8'hFF, 8'hFF);
    drain();
    check("carry_ff_ff", 32'(last_sum), 32'h1FE);

    // Backpressure: only DEPTH pairs accepted, fifth waits until the head is released.
    out_ready = 1'b0;
    start = push_cnt;
    for (int i = 0; i < DEPTH; i++) send(DW'(i), DW'(i));
    in_valid = 1'b1;
    in_a     = DW'(DEPTH);
    in_b     = DW'(DEPTH);
    repeat (3) tick();
    @(negedge clk);
    check("fill_accepted", 32'(push_cnt - start), 32'(DEPTH));
    check("fill_in_ready", 32'(in_ready), 32'd0);
    check("fill_level", 32'(out_level), 32'(DEPTH));
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && push_cnt - start == DEPTH; i++) tick();
    check("fifth_accepted", 32'(push_cnt - start), 32'(DEPTH + 1));
    in_valid = 1'b0;
    drain();
    check("fifth_sum", 32'(last_sum), 32'(2 * DEPTH));

    // Full FIFO with simultaneous push and pop keeps the level at DEPTH.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(DW'(8'h10 + i), DW'(8'h20));
    in_valid  = 1'b1;
    in_a      = 8'h07;
    in_b      = 8'h09;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("full_push_pop_level", 32'(out_level), 32'(DEPTH));
    drain();
    check("full_push_pop_tail", 32'(last_sum), 32'h010);

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      in_a      = DW'($urandom);
      in_b      = DW'($urandom);
      tick();
    end
    in_valid = 1'b0;
    drain();

    // Reset mid-stream discards buffered results.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(DW'(8'h40 + i), DW'(8'h01));
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
`ifdef ADD_RESP_COUNT_EN
    check("post_rst_txn", 32'(txn_count), 32'd0);
`endif
    tick();
    send(8'h21, 8'h10);
    drain();
    check("post_rst_sum", 32'(last_sum), 32'h031);

`ifdef ADD_RESP_COUNT_EN
    // Stream past 0xFFFF transfers so the counter wraps; the monitor tracks it modulo 2^16.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      in_a = DW'($urandom);
      in_b = DW'($urandom);
      tick();
    end
    in_valid = 1'b0;
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
